// File: rtl/mem_pkg.sv
// Shared types and default sizing for the cache-to-memory line arbiter.
package mem_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} arb_state_t;
  typedef enum logic {SRC_I, SRC_D} arb_src_t;

  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_WORD_W    = 32;
  localparam int DEF_ADDR_W    = 32;
  localparam int LINE_W        = DEF_BURST_LEN * DEF_WORD_W;
  localparam int OFFSET_W      = $clog2(LINE_W / 8);
  localparam int BEAT_W        = $clog2(DEF_BURST_LEN);

endpackage

// File: rtl/line_beat_buffer.sv
// BURST_LEN x WORD_W register file: one word written per beat, whole line read in parallel.
module line_beat_buffer #(
  parameter int BURST_LEN = 4,
  parameter int WORD_W    = 32,
  parameter int BEAT_W    = $clog2(BURST_LEN)
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        we_i,
  input  logic [BEAT_W-1:0]           widx_i,
  input  logic [WORD_W-1:0]           wdata_i,
  output logic [BURST_LEN*WORD_W-1:0] line_o
);

  logic [BURST_LEN-1:0][WORD_W-1:0] words_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      words_q <= '0;
    end else if (we_i) begin
      words_q[widx_i] <= wdata_i;
    end
  end

  assign line_o = words_q;

endmodule

// File: rtl/mem_line_arbiter.sv
// Arbitrates I/D cache line fills and D writebacks onto one burst memory port.
// ARB_ROUND_ROBIN_EN: ties go to the requester not served last; otherwise D always wins.
module mem_line_arbiter
  import mem_pkg::*;
#(
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        i_req_i,
  input  logic [ADDR_W-1:0]           i_addr_i,
  output logic [BURST_LEN*WORD_W-1:0] i_line_o,
  output logic                        i_done_o,
  input  logic                        d_req_i,
  input  logic                        d_we_i,
  input  logic [ADDR_W-1:0]           d_addr_i,
  input  logic [BURST_LEN*WORD_W-1:0] d_wline_i,
  output logic [BURST_LEN*WORD_W-1:0] d_rline_o,
  output logic                        d_done_o,
  output logic                        mem_re_o,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [WORD_W-1:0]           mem_din_o,
  input  logic [WORD_W-1:0]           mem_dout_i,
  input  logic                        mem_valid_i
);

  localparam int LW = BURST_LEN * WORD_W;
  localparam int OW = $clog2(LW / 8);
  localparam int BW = $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OW) - 64'd1);
  localparam logic [BW-1:0]     LAST_BEAT = BW'(BURST_LEN - 1);

  arb_state_t        state_q, state_d;
  arb_src_t          grant_q, grant_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              any_req, win_d, last_beat, buf_we;
  logic [LW-1:0]     line;

`ifdef ARB_ROUND_ROBIN_EN
  arb_src_t last_q, last_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) last_q <= SRC_I;
    else          last_q <= last_d;
  end

  assign win_d = d_req_i & (~i_req_i | (last_q == SRC_I));

  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE && any_req) last_d = win_d ? SRC_D : SRC_I;
  end
`else
  assign win_d = d_req_i;
`endif

  assign any_req   = i_req_i | d_req_i;
  assign last_beat = mem_valid_i && (beat_q == LAST_BEAT);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = (win_d && d_we_i) ? ST_WR : ST_RD;
      ST_RD,
      ST_WR:   if (last_beat) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_re_o  = (state_q == ST_RD);
    mem_we_o  = (state_q == ST_WR);
    i_done_o  = (state_q == ST_DONE) && (grant_q == SRC_I);
    d_done_o  = (state_q == ST_DONE) && (grant_q == SRC_D);
    buf_we    = (state_q == ST_RD) && mem_valid_i;
    mem_din_o = '0;
    if (state_q == ST_WR) mem_din_o = d_wline_i[beat_q*WORD_W +: WORD_W];
  end

  // Grant, aligned base address and beat counter
  always_comb begin
    grant_d = grant_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: if (any_req) begin
        grant_d = win_d ? SRC_D : SRC_I;
        addr_d  = (win_d ? d_addr_i : i_addr_i) & ~OFF_MASK;
        beat_d  = '0;
      end
      ST_RD,
      ST_WR:   if (mem_valid_i) beat_d = beat_q + 1'b1;
      default: beat_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      grant_q <= SRC_D;
      addr_q  <= '0;
      beat_q  <= '0;
    end else begin
      grant_q <= grant_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
    end
  end

  assign mem_addr_o = addr_q;

  line_beat_buffer #(
    .BURST_LEN (BURST_LEN),
    .WORD_W    (WORD_W),
    .BEAT_W    (BW)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (buf_we),
    .widx_i  (beat_q),
    .wdata_i (mem_dout_i),
    .line_o  (line)
  );

  // Both caches see the same fill register; each only trusts it while its DONE is high
  assign i_line_o  = line;
  assign d_rline_o = line;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Randomized bench for mem_line_arbiter with a latency-10 burst memory and a line-level model.
module tb_mem_line_arbiter;

  localparam int BL = 4;
  localparam int WW = 32;
  localparam int AW = 32;
  localparam int LW = BL * WW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [LW-1:0] d_wline = '0;
  logic [LW-1:0] i_line, d_rline;
  logic          i_done, d_done, mem_re, mem_we, mem_valid = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_din, mem_dout = '0;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: last fill line delivered, and who was served last (reset: I)
  logic [LW-1:0] model_line = '0;
  bit            last_d = 1'b0;

  always #5 clk = ~clk;

  mem_line_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_line_o(i_line), .i_done_o(i_done),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wline_i(d_wline),
    .d_rline_o(d_rline), .d_done_o(d_done),
    .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_din_o(mem_din),
    .mem_dout_i(mem_dout), .mem_valid_i(mem_valid)
  );

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic bit pick_d(bit ir, bit dr);
    if (!dr) return 1'b0;
    if (!ir) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  // Plays the memory for one burst and checks the whole transaction at line level
  task automatic serve(input bit src_d, input bit we, input logic [AW-1:0] addr,
                       input logic [LW-1:0] wline, input int gap[4]);
    int t;
    bit held;
    logic [WW-1:0] w[4];
    t = 0;
    while (!(mem_re | mem_we) && t < 20) begin tick(); t++; end
    if (!(mem_re | mem_we)) begin
      chk("start_timeout", 0, 1);
      return;
    end
    chk("mem_addr", mem_addr, addr & ~32'hF);
    chk("direction", {mem_we, mem_re}, we ? 2'b10 : 2'b01);
    held = 1'b1;
    repeat (10) begin tick(); held &= we ? mem_we : mem_re; end
    for (int b = 0; b < 4; b++) begin
      repeat (gap[b]) begin tick(); held &= we ? mem_we : mem_re; end
      w[b] = $urandom;
      mem_dout = w[b];
      mem_valid = 1'b1;
      if (we) chk($sformatf("mem_din%0d", b), mem_din, wline[b*WW +: WW]);
      tick();
      mem_valid = 1'b0;
      mem_dout = '0;
      if (b < 3) held &= we ? mem_we : mem_re;
    end
    chk("burst_held", held, 1);
    chk("done_re_we_low", {mem_re, mem_we}, 0);
    chk("i_done", i_done, !src_d);
    chk("d_done", d_done, src_d);
    if (!we) begin
      model_line = {w[3], w[2], w[1], w[0]};
      chk(src_d ? "d_rline" : "i_line", src_d ? d_rline : i_line, model_line);
    end
    if (src_d) d_req = 1'b0; else i_req = 1'b0;
    last_d = src_d;
    tick();
    chk("done_one_cycle", {i_done, d_done}, 0);
  endtask

  initial begin
    int g[4];
    bit ir, dr, fd;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_outputs", {mem_re, mem_we, i_done, d_done}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_line", i_line, 0);

    // I fill at 0x104, gap-free beats
    g = '{0, 0, 0, 0};
    i_addr = 32'h104; i_req = 1'b1;
    serve(1'b0, 1'b0, 32'h104, '0, g);

    // D writeback at 0x20
    d_addr = 32'h20; d_we = 1'b1;
    d_wline = {32'd4, 32'd3, 32'd2, 32'd1};
    d_req = 1'b1;
    serve(1'b1, 1'b1, 32'h20, d_wline, g);
    d_we = 1'b0;

    // Simultaneous requests after a D service
    i_addr = 32'h1000; d_addr = 32'h2008; i_req = 1'b1; d_req = 1'b1;
    fd = pick_d(1'b1, 1'b1);
    serve(fd, 1'b0, fd ? d_addr : i_addr, '0, g);
    serve(!fd, 1'b0, fd ? i_addr : d_addr, '0, g);

    // Gapped beats: 0,3,0 between beats
    g = '{0, 0, 3, 0};
    i_addr = 32'hABC; i_req = 1'b1;
    serve(1'b0, 1'b0, 32'hABC, '0, g);

    // MEM_VALID strobes while idle must be ignored
    repeat (3) begin
      mem_valid = 1'b1; mem_dout = $urandom;
      tick();
    end
    mem_valid = 1'b0;
    chk("idle_valid_line", i_line, model_line);
    chk("idle_valid_ctrl", {mem_re, mem_we, i_done, d_done}, 0);

    // Reset after beat 2 of a read
    i_addr = 32'h340; i_req = 1'b1;
    for (int t = 0; t < 20 && !mem_re; t++) tick();
    chk("rst_test_start", mem_re, 1);
    repeat (10) tick();
    for (int b = 0; b < 2; b++) begin
      mem_valid = 1'b1; mem_dout = $urandom;
      tick();
    end
    mem_valid = 1'b0;
    rst_n = 1'b0; i_req = 1'b0;
    tick();
    chk("midrst_re", mem_re, 0);
    rst_n = 1'b1;
    model_line = '0;
    last_d = 1'b0;
    repeat (3) begin
      tick();
      chk("midrst_no_done", {i_done, d_done, mem_re}, 0);
    end
    chk("midrst_line", i_line, model_line);
    g = '{1, 0, 2, 1};
    i_addr = 32'h344; i_req = 1'b1;
    serve(1'b0, 1'b0, 32'h344, '0, g);

    // Random traffic
    for (int k = 0; k < 16; k++) begin
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) dr = 1'b1;
      i_addr = $urandom; d_addr = $urandom; d_we = 1'($urandom_range(0, 1));
      d_wline = {$urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < 4; j++) g[j] = $urandom_range(0, 2);
      i_req = ir; d_req = dr;
      fd = pick_d(ir, dr);
      serve(fd, fd ? d_we : 1'b0, fd ? d_addr : i_addr, d_wline, g);
      if (ir && dr) serve(!fd, fd ? 1'b0 : d_we, fd ? i_addr : d_addr, d_wline, g);
      d_we = 1'b0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
